// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the PWM peripheral and the SPI register map.
package pwm_pkg;
    localparam int CNT_W       = 8;
    localparam int CLK_DIV_DEF = 13;
    localparam logic [CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam logic [7:0] ADDR_EN_OUT_LO = 8'h00;
    localparam logic [7:0] ADDR_EN_OUT_HI = 8'h01;
    localparam logic [7:0] ADDR_EN_PWM_LO = 8'h02;
    localparam logic [7:0] ADDR_EN_PWM_HI = 8'h03;
    localparam logic [7:0] ADDR_DUTY      = 8'h04;
    // Full duty is forced high so 0xFF is a true 100% rather than 255/256.
    function automatic logic pwm_level(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: counts 0..CLK_DIV-1 and flags the last count as the PWM step tick.
module pwm_prescaler #(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    logic [W-1:0] r_cnt;
    assign o_tick = (r_cnt == LAST);
    always_ff @(posedge clk) begin
        r_cnt <= (rst || o_tick) ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 outputs off, high, or from a shared 8-bit PWM.
// Define PWM_DUTY_SHADOW_EN to latch the duty only at period boundaries.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);
    logic             w_tick;
    logic             w_wrap;
    logic             w_pwm;
    logic [15:0]      w_en_out;
    logic [15:0]      w_en_pwm;
    logic [CNT_W-1:0] w_duty;
    logic [CNT_W-1:0] r_pwm_cnt;
    logic [15:0]      r_out;
    logic             r_period_start;

    pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_wrap   = w_tick && (r_pwm_cnt == '1);

`ifdef PWM_DUTY_SHADOW_EN
    logic [CNT_W-1:0] r_duty;
    always_ff @(posedge clk) begin
        if (rst)
            r_duty <= '0;
        else if (w_wrap)
            r_duty <= pwm_duty_cycle;
    end
    assign w_duty = r_duty;
`else
    assign w_duty = pwm_duty_cycle;
`endif

    assign w_pwm = pwm_level(r_pwm_cnt, w_duty);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt      <= '0;
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            if (w_tick)
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_out          <= w_en_out & (~w_en_pwm | {16{w_pwm}});
            r_period_start <= w_wrap;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;
endmodule
